demux4_stream: RTL and testbench
================================

DEMUX4_STREAM -- requirements
Module: demux4_stream

Interface
REQ-001 Parameter: W, 4, data width of the input and of every output port.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  source offers a word this cycle.
REQ-005 in_ready  output  1  block accepts the offered word this cycle.
REQ-006 in_data  input  W  offered data word.
REQ-007 in_sel  input  2  destination port index 0..3 for the offered word.
REQ-008 out_valid  output  4  bit k: port k head word valid.
REQ-009 out_ready  input  4  bit k: sink k takes the port k head word.
REQ-010 out_data0..out_data3  output  W each  head word of port 0..3.
REQ-011 cnt0..cnt3  output  8 each  per-port delivered-word counters; present only when DEMUX4_STATS_EN is defined.

Function
REQ-012 The block routes each accepted word to the port named by in_sel; it is the inverse of the 4:1 data selector, with a 2-entry FIFO per port.
REQ-013 Input transfer occurs when in_valid && in_ready at a rising edge; output transfer on port k occurs when out_valid[k] && out_ready[k].
REQ-014 in_ready SHALL be 1 exactly when the FIFO of port in_sel is not FULL (registered state); in_ready does not depend on out_ready.
REQ-015 Each port FIFO has states EMPTY, ONE, FULL; out_valid[k]=1 in ONE and FULL.
REQ-016 Transitions: push only -> EMPTY->ONE, ONE->FULL; pop only -> FULL->ONE, ONE->EMPTY; push and pop in ONE -> stay ONE, head replaced by pushed word; push and pop in FULL is impossible (push blocked); pop in EMPTY is ignored.
REQ-017 Latency: word accepted at edge N is visible on out_data[k] with out_valid[k]=1 from edge N (i.e. the following cycle) when the port was EMPTY or popping from ONE.
REQ-018 Order within a port SHALL be preserved; words to different ports are independent.
REQ-019 Ports not addressed by in_sel SHALL not change except by their own pops.
REQ-020 out_data[k] SHALL hold its last value when out_valid[k]=0; the value is don't-care for checking.
REQ-021 A stalled port (FULL) SHALL block only input words addressed to it; in_data/in_sel may change while in_valid=1 and in_ready=0.

Reset
REQ-022 While rst_n=0: all FIFOs EMPTY, out_valid=4'b0000, in_ready=1, out_data0..3=0, cnt0..3=0.
REQ-023 Assertion of rst_n mid-operation SHALL discard all buffered words immediately, without waiting for clk.
REQ-024 The first transfer after deassertion is possible at the first rising edge with rst_n=1.

Configuration
REQ-025 Macro DEMUX4_STATS_EN: when defined, cnt0..cnt3 exist and cnt k increments by 1 on each output transfer of port k, saturating at 255 (no wrap).
REQ-026 Without DEMUX4_STATS_EN, cnt0..cnt3 ports and counter logic are absent; all other behaviour is identical.

Verification
REQ-027 Reset, then push 4'hA to sel 2 with out_ready=4'hF -> out_valid=4'b0100, out_data2=4'hA next cycle, popped the cycle after, port 0/1/3 untouched.
REQ-028 out_ready=0, push 4'h1,4'h2,4'h3 to sel 1 on consecutive cycles -> third word sees in_ready=0; port 1 FULL; after out_ready[1]=1 delivers 4'h1 then 4'h2, then 4'h3 accepted.
REQ-029 Port 0 FULL, push 4'h5 to sel 3 -> in_ready=1 and out_data3=4'h5 next cycle while port 0 holds.
REQ-030 Port 2 in ONE with head 4'h7, simultaneous push 4'h8 and pop -> 4'h7 delivered, state stays ONE, head 4'h8.
REQ-031 Fill ports 0 and 3, assert rst_n=0 between clock edges -> out_valid=0 and in_ready=1 immediately; no stale word appears after release.
REQ-032 With DEMUX4_STATS_EN, deliver 300 words to port 0 -> cnt0=255, other counters 0; without the macro the same traffic passes and the build has no cnt ports.

Source files
------------

// File: rtl/demux4_stream.sv
// demux4_stream: 1-to-4 stream demultiplexer with a 2-entry FIFO behind each output port.
// Optional per-port delivered-word counters are compiled in when DEMUX4_STATS_EN is defined.
module demux4_stream #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_sel,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [W-1:0] out_data0,
    output logic [W-1:0] out_data1,
    output logic [W-1:0] out_data2,
    output logic [W-1:0] out_data3
`ifdef DEMUX4_STATS_EN
    ,
    output logic [7:0]   cnt0,
    output logic [7:0]   cnt1,
    output logic [7:0]   cnt2,
    output logic [7:0]   cnt3
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_e;

    fifo_state_e  state_q [4];
    fifo_state_e  state_d [4];
    logic [W-1:0] head_q  [4];
    logic [W-1:0] head_d  [4];
    logic [W-1:0] tail_q  [4];
    logic [W-1:0] tail_d  [4];
    logic [3:0]   push;
    logic [3:0]   pop;

    // State register: per-port FIFO occupancy plus its two data slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= ST_EMPTY;
                head_q[k]  <= '0;
                tail_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                head_q[k]  <= head_d[k];
                tail_q[k]  <= tail_d[k];
            end
        end
    end

    // Next-state logic; a push in FULL cannot occur because in_ready blocks it.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            head_d[k]  = head_q[k];
            tail_d[k]  = tail_q[k];
            case (state_q[k])
                ST_EMPTY: begin
                    if (push[k]) begin
                        state_d[k] = ST_ONE;
                        head_d[k]  = in_data;
                    end
                end
                ST_ONE: begin
                    if (push[k] && pop[k]) begin
                        head_d[k] = in_data;
                    end else if (push[k]) begin
                        state_d[k] = ST_FULL;
                        tail_d[k]  = in_data;
                    end else if (pop[k]) begin
                        state_d[k] = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop[k]) begin
                        state_d[k] = ST_ONE;
                        head_d[k]  = tail_q[k];
                    end
                end
                default: begin
                    state_d[k] = ST_EMPTY;
                end
            endcase
        end
    end

    // Output logic: handshakes derive only from registered occupancy.
    always_comb begin
        in_ready  = (state_q[in_sel] != ST_FULL);
        out_valid = '0;
        push      = '0;
        pop       = '0;
        for (int k = 0; k < 4; k++) begin
            out_valid[k] = (state_q[k] != ST_EMPTY);
            pop[k]       = out_valid[k] && out_ready[k];
            push[k]      = in_valid && in_ready && (in_sel == 2'(k));
        end
    end

    assign out_data0 = head_q[0];
    assign out_data1 = head_q[1];
    assign out_data2 = head_q[2];
    assign out_data3 = head_q[3];

`ifdef DEMUX4_STATS_EN
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];

    // Delivered-word counters saturate rather than wrap.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k];
            if (pop[k] && (cnt_q[k] != 8'hFF)) begin
                cnt_d[k] = cnt_q[k] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Scoreboard testbench for demux4_stream: per-port expected-word queues filled on accepted
// input words and drained/compared on output transfers, plus scenario tasks with direct checks.
module tb_demux4_stream;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX4_STATS_EN
    logic [7:0]   cnt0, cnt1, cnt2, cnt3;
`endif

    int passed = 0;
    int total  = 0;
    int exp_cnt  [4];
    int dut_pops [4];
    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];
    logic [W-1:0] q2 [$];
    logic [W-1:0] q3 [$];

    demux4_stream #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3)
`ifdef DEMUX4_STATS_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int sb_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic sb_push(input int k, input logic [W-1:0] d);
        case (k)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            2:       q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic sb_pop(input int k, output logic [W-1:0] d);
        case (k)
            0:       d = q0.pop_front();
            1:       d = q1.pop_front();
            2:       d = q2.pop_front();
            default: d = q3.pop_front();
        endcase
    endtask

    task automatic sb_clear();
        q0.delete();
        q1.delete();
        q2.delete();
        q3.delete();
        for (int k = 0; k < 4; k++) begin
            exp_cnt[k]  = 0;
            dut_pops[k] = 0;
        end
    endtask

    function automatic logic [W-1:0] dut_data(input int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

`ifdef DEMUX4_STATS_EN
    function automatic logic [7:0] dut_cnt(input int k);
        case (k)
            0:       return cnt0;
            1:       return cnt1;
            2:       return cnt2;
            default: return cnt3;
        endcase
    endfunction
`endif

    // Scoreboard monitor: samples mid-cycle, predicts the transfers of the coming rising edge.
    logic         mon_rdy;
    logic         mon_vld;
    logic [W-1:0] mon_exp;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon_rdy = (sb_size(int'(in_sel)) < 2);
            total++;
            if (in_ready !== mon_rdy)
                $display("[TB] FAIL mon_in_ready sel=%0d: got %b, expected %b", in_sel, in_ready, mon_rdy);
            else
                passed++;
            for (int k = 0; k < 4; k++) begin
                mon_vld = (sb_size(k) != 0);
                total++;
                if (out_valid[k] !== mon_vld)
                    $display("[TB] FAIL mon_out_valid%0d: got %b, expected %b", k, out_valid[k], mon_vld);
                else
                    passed++;
`ifdef DEMUX4_STATS_EN
                total++;
                if (dut_cnt(k) !== 8'(exp_cnt[k]))
                    $display("[TB] FAIL mon_cnt%0d: got %0d, expected %0d", k, dut_cnt(k), exp_cnt[k]);
                else
                    passed++;
`endif
                if (out_valid[k] === 1'b1 && out_ready[k] === 1'b1)
                    dut_pops[k]++;
                if (mon_vld && out_ready[k] === 1'b1) begin
                    sb_pop(k, mon_exp);
                    total++;
                    if (dut_data(k) !== mon_exp)
                        $display("[TB] FAIL mon_out_data%0d: got %h, expected %h", k, dut_data(k), mon_exp);
                    else
                        passed++;
                    if (exp_cnt[k] < 255)
                        exp_cnt[k]++;
                end
            end
            if (in_valid === 1'b1 && mon_rdy)
                sb_push(int'(in_sel), in_data);
        end
    end

    task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                                 input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sb_clear();
        applyStimulus(1'b0, 2'd0, '0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 4'b0000) $display("[TB] FAIL reset_out_valid: got %b, expected 0000", out_valid);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (dut_data(k) !== '0) $display("[TB] FAIL reset_out_data%0d: got %h, expected 0", k, dut_data(k));
            else passed++;
`ifdef DEMUX4_STATS_EN
            total++;
            if (dut_cnt(k) !== 8'd0) $display("[TB] FAIL reset_cnt%0d: got %0d, expected 0", k, dut_cnt(k));
            else passed++;
`endif
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_route();
        applyStimulus(1'b1, 2'd2, 4'hA, 4'hF);
        tick();
        applyStimulus(1'b0, 2'd0, 4'h0, 4'hF);
        total++;
        if (out_valid !== 4'b0100) $display("[TB] FAIL route_valid: got %b, expected 0100", out_valid);
        else passed++;
        total++;
        if (out_data2 !== 4'hA) $display("[TB] FAIL route_data2: got %h, expected a", out_data2);
        else passed++;
        tick();
        total++;
        if (out_valid !== 4'b0000) $display("[TB] FAIL route_popped: got %b, expected 0000", out_valid);
        else passed++;
        total++;
        if ({out_data0, out_data1, out_data3} !== 12'h000)
            $display("[TB] FAIL route_untouched: got %h, expected 000", {out_data0, out_data1, out_data3});
        else passed++;
    endtask

    task automatic test_full_stall();
        applyStimulus(1'b1, 2'd1, 4'h1, 4'h0);
        tick();
        applyStimulus(1'b1, 2'd1, 4'h2, 4'h0);
        tick();
        applyStimulus(1'b1, 2'd1, 4'h3, 4'h0);
        total++;
        if (in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready: got %b, expected 0", in_ready);
        else passed++;
        tick();
        total++;
        if (out_valid[1] !== 1'b1 || out_data1 !== 4'h1)
            $display("[TB] FAIL stall_head: got %b/%h, expected 1/1", out_valid[1], out_data1);
        else passed++;
        applyStimulus(1'b1, 2'd1, 4'h3, 4'b0010);
        tick();
        total++;
        if (out_data1 !== 4'h2) $display("[TB] FAIL stall_second: got %h, expected 2", out_data1);
        else passed++;
        applyStimulus(1'b1, 2'd1, 4'h3, 4'b0010);
        total++;
        if (in_ready !== 1'b1) $display("[TB] FAIL stall_release: got %b, expected 1", in_ready);
        else passed++;
        tick();
        applyStimulus(1'b0, 2'd0, 4'h0, 4'b0010);
        total++;
        if (out_data1 !== 4'h3) $display("[TB] FAIL stall_third: got %h, expected 3", out_data1);
        else passed++;
        tick();
        total++;
        if (out_valid !== 4'b0000) $display("[TB] FAIL stall_drained: got %b, expected 0000", out_valid);
        else passed++;
    endtask

    task automatic test_independent_ports();
        applyStimulus(1'b1, 2'd0, 4'hC, 4'h0);
        tick();
        applyStimulus(1'b1, 2'd0, 4'hD, 4'h0);
        tick();
        applyStimulus(1'b1, 2'd3, 4'h5, 4'h0);
        total++;
        if (in_ready !== 1'b1) $display("[TB] FAIL indep_in_ready: got %b, expected 1", in_ready);
        else passed++;
        tick();
        applyStimulus(1'b0, 2'd0, 4'h0, 4'h0);
        total++;
        if (out_valid !== 4'b1001 || out_data3 !== 4'h5 || out_data0 !== 4'hC)
            $display("[TB] FAIL indep_state: got %b/%h/%h, expected 1001/5/c", out_valid, out_data3, out_data0);
        else passed++;
        applyStimulus(1'b0, 2'd0, 4'h0, 4'hF);
        repeat (2) tick();
        total++;
        if (out_valid !== 4'b0000) $display("[TB] FAIL indep_drained: got %b, expected 0000", out_valid);
        else passed++;
    endtask

    task automatic test_push_pop_one();
        applyStimulus(1'b1, 2'd2, 4'h7, 4'h0);
        tick();
        applyStimulus(1'b1, 2'd2, 4'h8, 4'b0100);
        total++;
        if (in_ready !== 1'b1 || out_data2 !== 4'h7)
            $display("[TB] FAIL pp_before: got %b/%h, expected 1/7", in_ready, out_data2);
        else passed++;
        tick();
        applyStimulus(1'b0, 2'd0, 4'h0, 4'h0);
        total++;
        if (out_valid !== 4'b0100 || out_data2 !== 4'h8)
            $display("[TB] FAIL pp_after: got %b/%h, expected 0100/8", out_valid, out_data2);
        else passed++;
        tick();
        applyStimulus(1'b1, 2'd2, 4'h9, 4'h0);
        total++;
        if (in_ready !== 1'b1) $display("[TB] FAIL pp_still_one: got %b, expected 1", in_ready);
        else passed++;
        applyStimulus(1'b0, 2'd0, 4'h0, 4'b0100);
        tick();
        total++;
        if (out_valid !== 4'b0000) $display("[TB] FAIL pp_drained: got %b, expected 0000", out_valid);
        else passed++;
    endtask

    task automatic test_async_reset();
        applyStimulus(1'b1, 2'd0, 4'hE, 4'h0);
        tick();
        applyStimulus(1'b1, 2'd0, 4'hF, 4'h0);
        tick();
        applyStimulus(1'b1, 2'd3, 4'h1, 4'h0);
        tick();
        applyStimulus(1'b1, 2'd3, 4'h2, 4'h0);
        tick();
        applyStimulus(1'b0, 2'd0, 4'h0, 4'h0);
        rst_n = 1'b0;
        sb_clear();
        #1;
        total++;
        if (out_valid !== 4'b0000 || in_ready !== 1'b1)
            $display("[TB] FAIL async_immediate: got %b/%b, expected 0000/1", out_valid, in_ready);
        else passed++;
        applyStimulus(1'b1, 2'd1, 4'h9, 4'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b0, 2'd0, 4'h0, 4'hF);
        total++;
        if (out_valid !== 4'b0010 || out_data1 !== 4'h9)
            $display("[TB] FAIL async_first_xfer: got %b/%h, expected 0010/9", out_valid, out_data1);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 4'b0000) $display("[TB] FAIL async_no_stale: got %b, expected 0000", out_valid);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          W'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            tick();
        end
        applyStimulus(1'b0, 2'd0, 4'h0, 4'hF);
        repeat (3) tick();
        total++;
        if (out_valid !== 4'b0000) $display("[TB] FAIL random_drained: got %b, expected 0000", out_valid);
        else passed++;
    endtask

    task automatic test_stats();
        int guard;
        test_reset();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 2'd0, W'(i), 4'b0001);
            tick();
        end
        applyStimulus(1'b0, 2'd0, 4'h0, 4'b0001);
        guard = 0;
        while (out_valid[0] === 1'b1 && guard < 5) begin
            tick();
            guard++;
        end
        tick();
        total++;
        if (out_valid[0] !== 1'b0) $display("[TB] FAIL stats_drain_timeout: got %b, expected 0", out_valid[0]);
        else passed++;
        total++;
        if (dut_pops[0] !== 300) $display("[TB] FAIL stats_delivered: got %0d, expected 300", dut_pops[0]);
        else passed++;
`ifdef DEMUX4_STATS_EN
        total++;
        if (cnt0 !== 8'd255) $display("[TB] FAIL stats_cnt0: got %0d, expected 255", cnt0);
        else passed++;
        total++;
        if ({cnt1, cnt2, cnt3} !== 24'd0) $display("[TB] FAIL stats_others: got %h, expected 000000", {cnt1, cnt2, cnt3});
        else passed++;
`endif
    endtask

    initial begin
        rst_n = 1'b1;
        sb_clear();
        applyStimulus(1'b0, 2'd0, '0, 4'h0);
        #1;
        test_reset();
        test_single_route();
        test_full_stall();
        test_independent_ports();
        test_push_pop_one();
        test_async_reset();
        test_back_to_back();
        test_stats();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
